// File: rtl/snake_body_track_if.sv
// Handshake bundle between the snake state owner and its driver/observer:
// step controls and food picker inputs in, registered board state out.
interface snake_body_track_if #(
   parameter int SCORE_W = 4
);
   logic               start;
   logic               tick;
   logic [1:0]         dir_req;
   logic [5:0]         new_food_idx;
   logic [3:0]         rnd_a;
   logic [3:0]         rnd_b;
   logic [5:0]         idx_head_next;
   logic [5:0]         idx_head_now;
   logic [5:0]         idx0_now;
   logic [5:0]         idx1_now;
   logic [5:0]         idx2_now;
   logic [5:0]         food_idx;
   logic [SCORE_W-1:0] score;
   logic               running;
   logic               game_over;
   logic               win;
   logic               ate;

   modport master (
      output start, tick, dir_req, new_food_idx,
      input  rnd_a, rnd_b, idx_head_next, idx_head_now, idx0_now, idx1_now,
             idx2_now, food_idx, score, running, game_over, win, ate
   );

   modport slave (
      input  start, tick, dir_req, new_food_idx,
      output rnd_a, rnd_b, idx_head_next, idx_head_now, idx0_now, idx1_now,
             idx2_now, food_idx, score, running, game_over, win, ate
   );
endinterface

// File: rtl/snake_body_track.sv
// Sequential state owner for the 8x8 snake game: head, three body segments,
// food, direction, score, game FSM and the two LFSRs feeding the food picker.
module snake_body_track #(
   parameter logic [5:0] FOOD_INIT = 6'd45,
   parameter int         SCORE_W   = 4,
   parameter logic [SCORE_W-1:0] SCORE_MAX = 4'd15
) (
   input  logic                clk,
   input  logic                rst,
   snake_body_track_if.slave   bus
);
   typedef enum logic [1:0] {IDLE, RUN, OVER, WIN} state_e;

   state_e             state_q;
   logic [5:0]         head_q, seg0_q, seg1_q, seg2_q, food_q;
   logic [1:0]         dir_q;
   logic [SCORE_W-1:0] score_q;
   logic               ate_q;
   logic [3:0]         rndA_q, rndB_q;

   logic [3:0]         rndA_d, rndB_d;
   logic [1:0]         effDir;
   logic [2:0]         nextRow, nextCol;
   logic [5:0]         headNext_d;
   logic               wallHit, selfHit, eatHit;
   logic [SCORE_W-1:0] scoreInc;

   assign rndA_d = {rndA_q[2:0], rndA_q[3] ^ rndA_q[2]};
   assign rndB_d = {rndB_q[2:0], rndB_q[3] ^ rndB_q[2]};

   // A request for the exact opposite direction is refused; the snake keeps going.
   always_comb begin
      effDir  = (bus.dir_req == (dir_q ^ 2'b10)) ? dir_q : bus.dir_req;
      nextRow = head_q[5:3];
      nextCol = head_q[2:0];
      wallHit = 1'b0;
      case (effDir)
         2'b00: begin
            nextRow = head_q[5:3] - 3'd1;
            wallHit = (head_q[5:3] == 3'd0);
         end
         2'b01: begin
            nextCol = head_q[2:0] + 3'd1;
            wallHit = (head_q[2:0] == 3'd7);
         end
         2'b10: begin
            nextRow = head_q[5:3] + 3'd1;
            wallHit = (head_q[5:3] == 3'd7);
         end
         default: begin
            nextCol = head_q[2:0] - 3'd1;
            wallHit = (head_q[2:0] == 3'd0);
         end
      endcase
   end

   assign headNext_d = {nextRow, nextCol};
   assign selfHit    = (headNext_d == seg0_q) || (headNext_d == seg1_q);
   assign eatHit     = (headNext_d == food_q);
   assign scoreInc   = score_q + SCORE_W'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         head_q  <= 6'd27;
         seg0_q  <= 6'd26;
         seg1_q  <= 6'd25;
         seg2_q  <= 6'd24;
         dir_q   <= 2'b01;
         food_q  <= FOOD_INIT;
         score_q <= '0;
         ate_q   <= 1'b0;
         rndA_q  <= 4'b1001;
         rndB_q  <= 4'b0110;
      end else begin
         rndA_q <= rndA_d;
         rndB_q <= rndB_d;
         ate_q  <= 1'b0;
         case (state_q)
            RUN: begin
               if (bus.tick) begin
                  if (wallHit || selfHit) begin
                     state_q <= OVER;
                  end else begin
                     seg2_q <= seg1_q;
                     seg1_q <= seg0_q;
                     seg0_q <= head_q;
                     head_q <= headNext_d;
                     dir_q  <= effDir;
                     if (eatHit) begin
                        food_q  <= bus.new_food_idx;
                        score_q <= scoreInc;
                        ate_q   <= 1'b1;
                        if (scoreInc == SCORE_MAX) begin
                           state_q <= WIN;
                        end
                     end
                  end
               end
            end
            default: begin
               // IDLE, OVER and WIN all restart the board on start; tick is ignored here.
               if (bus.start) begin
                  state_q <= RUN;
                  head_q  <= 6'd27;
                  seg0_q  <= 6'd26;
                  seg1_q  <= 6'd25;
                  seg2_q  <= 6'd24;
                  dir_q   <= 2'b01;
                  food_q  <= FOOD_INIT;
                  score_q <= '0;
               end
            end
         endcase
      end
   end

   assign bus.rnd_a         = rndA_q;
   assign bus.rnd_b         = rndB_q;
   assign bus.idx_head_next = headNext_d;
   assign bus.idx_head_now  = head_q;
   assign bus.idx0_now      = seg0_q;
   assign bus.idx1_now      = seg1_q;
   assign bus.idx2_now      = seg2_q;
   assign bus.food_idx      = food_q;
   assign bus.score         = score_q;
   assign bus.running       = (state_q == RUN);
   assign bus.game_over     = (state_q == OVER);
   assign bus.win           = (state_q == WIN);
   assign bus.ate           = ate_q;
endmodule

// File: tb/tb_snake_body_track.sv
// Bench for snake_body_track: directed literal checks, a second instance with a
// tiny win score, and a random phase compared every cycle against a board model.
module tb_snake_body_track;
   logic clk;
   logic rst;
   int   compared;
   int   mismatched;
   bit   checkEn;

   snake_body_track_if #(.SCORE_W(4)) sb ();
   snake_body_track_if #(.SCORE_W(4)) sb2 ();

   snake_body_track #(.FOOD_INIT(6'd45), .SCORE_W(4), .SCORE_MAX(4'd15)) dut (
      .clk(clk), .rst(rst), .bus(sb)
   );

   snake_body_track #(.FOOD_INIT(6'd28), .SCORE_W(4), .SCORE_MAX(4'd1)) dut2 (
      .clk(clk), .rst(rst), .bus(sb2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_OVER = 2;
   localparam int S_WIN  = 3;

   int mState, mDir, mFood, mScore, mAte, mRa, mRb;
   int mRow[4];
   int mCol[4];

   function automatic int dRow(int d);
      return (d == 0) ? -1 : ((d == 2) ? 1 : 0);
   endfunction

   function automatic int dCol(int d);
      return (d == 1) ? 1 : ((d == 3) ? -1 : 0);
   endfunction

   function automatic int cellOf(int r, int c);
      return ((r + 8) % 8) * 8 + ((c + 8) % 8);
   endfunction

   function automatic int effDirOf(int req, int cur);
      if (dRow(req) == -dRow(cur) && dCol(req) == -dCol(cur)) return cur;
      return req;
   endfunction

   function automatic int lfsrStep(int r);
      return ((r << 1) | (((r >> 3) ^ (r >> 2)) & 1)) & 15;
   endfunction

   task automatic newBoard();
      for (int i = 0; i < 4; i++) begin
         mRow[i] = 3;
         mCol[i] = 3 - i;
      end
      mDir   = 1;
      mFood  = 45;
      mScore = 0;
   endtask

   // Board model: advances on every clock edge from the same inputs the DUT sees.
   always @(posedge clk) begin
      int e, nr, nc, nAte;
      if (rst) begin
         newBoard();
         mState = S_IDLE;
         mAte   = 0;
         mRa    = 9;
         mRb    = 6;
      end else begin
         mRa  = lfsrStep(mRa);
         mRb  = lfsrStep(mRb);
         nAte = 0;
         if (mState != S_RUN) begin
            if (sb.start) begin
               newBoard();
               mState = S_RUN;
            end
         end else if (sb.tick) begin
            e  = effDirOf(sb.dir_req, mDir);
            nr = mRow[0] + dRow(e);
            nc = mCol[0] + dCol(e);
            if (nr < 0 || nr > 7 || nc < 0 || nc > 7 ||
                cellOf(nr, nc) == cellOf(mRow[1], mCol[1]) ||
                cellOf(nr, nc) == cellOf(mRow[2], mCol[2])) begin
               mState = S_OVER;
            end else begin
               for (int i = 3; i > 0; i--) begin
                  mRow[i] = mRow[i-1];
                  mCol[i] = mCol[i-1];
               end
               mRow[0] = nr;
               mCol[0] = nc;
               mDir    = e;
               if (cellOf(nr, nc) == mFood) begin
                  mFood  = sb.new_food_idx;
                  mScore = mScore + 1;
                  nAte   = 1;
                  if (mScore == 15) mState = S_WIN;
               end
            end
         end
         mAte = nAte;
      end
   end

   task automatic checkOutput(string name, int actual, int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clk) begin
      int e;
      if (checkEn) begin
         e = effDirOf(sb.dir_req, mDir);
         checkOutput("head",      sb.idx_head_now, cellOf(mRow[0], mCol[0]));
         checkOutput("idx0",      sb.idx0_now,     cellOf(mRow[1], mCol[1]));
         checkOutput("idx1",      sb.idx1_now,     cellOf(mRow[2], mCol[2]));
         checkOutput("idx2",      sb.idx2_now,     cellOf(mRow[3], mCol[3]));
         checkOutput("headNext",  sb.idx_head_next,
                     cellOf(mRow[0] + dRow(e), mCol[0] + dCol(e)));
         checkOutput("food",      sb.food_idx,  mFood);
         checkOutput("score",     sb.score,     mScore);
         checkOutput("running",   sb.running,   int'(mState == S_RUN));
         checkOutput("gameOver",  sb.game_over, int'(mState == S_OVER));
         checkOutput("win",       sb.win,       int'(mState == S_WIN));
         checkOutput("ate",       sb.ate,       mAte);
         checkOutput("rndA",      sb.rnd_a,     mRa);
         checkOutput("rndB",      sb.rnd_b,     mRb);
      end
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Mostly steers toward the food so eating and winning actually happen.
   task automatic applyStimulus();
      int d;
      rst = ($urandom_range(399) == 0);
      if (mState != S_RUN) sb.start = ($urandom_range(3) == 0);
      else                 sb.start = ($urandom_range(15) == 0);
      sb.tick = $urandom_range(1);
      if ($urandom_range(9) < 8) begin
         if      (mFood / 8 > mRow[0]) d = 2;
         else if (mFood / 8 < mRow[0]) d = 0;
         else if (mFood % 8 > mCol[0]) d = 1;
         else                          d = 3;
      end else begin
         d = $urandom_range(3);
      end
      sb.dir_req      = 2'(d);
      sb.new_food_idx = 6'($urandom_range(63));
      stepCycle();
   endtask

   initial begin
      compared   = 0;
      mismatched = 0;
      checkEn    = 1'b0;
      rst        = 1'b1;
      sb.start = 1'b0;  sb.tick = 1'b0;  sb.dir_req = 2'd1;  sb.new_food_idx = 6'd0;
      sb2.start = 1'b0; sb2.tick = 1'b0; sb2.dir_req = 2'd1; sb2.new_food_idx = 6'd0;

      stepCycle();
      checkEn = 1'b1;
      rst     = 1'b0;
      checkOutput("lit.rstHead", sb.idx_head_now, 27);
      checkOutput("lit.rstIdx0", sb.idx0_now, 26);
      checkOutput("lit.rstIdx2", sb.idx2_now, 24);
      checkOutput("lit.rstFood", sb.food_idx, 45);
      checkOutput("lit.rstRndA0", sb.rnd_a, 9);
      stepCycle();
      checkOutput("lit.rndA1", sb.rnd_a, 3);
      checkOutput("lit.rndB1", sb.rnd_b, 13);
      stepCycle();
      checkOutput("lit.rndA2", sb.rnd_a, 6);

      sb.start = 1'b1;
      stepCycle();
      sb.start = 1'b0;
      sb.tick  = 1'b1;
      for (int i = 0; i < 4; i++) stepCycle();
      checkOutput("lit.edgeHead", sb.idx_head_now, 31);
      checkOutput("lit.edgeIdx0", sb.idx0_now, 30);
      stepCycle();
      checkOutput("lit.wallOver", sb.game_over, 1);
      checkOutput("lit.wallHead", sb.idx_head_now, 31);

      sb.tick  = 1'b0;
      sb.start = 1'b1;
      stepCycle();
      sb.start   = 1'b0;
      sb.dir_req = 2'd3;
      sb.tick    = 1'b1;
      stepCycle();
      checkOutput("lit.revHead", sb.idx_head_now, 28);
      sb.tick = 1'b0;
      #1;
      checkOutput("lit.revNext", sb.idx_head_next, 29);

      sb.dir_req = 2'd2;
      sb.tick    = 1'b1;
      stepCycle();
      stepCycle();
      sb.dir_req      = 2'd1;
      sb.new_food_idx = 6'd10;
      stepCycle();
      checkOutput("lit.eatHead", sb.idx_head_now, 45);
      checkOutput("lit.eatFood", sb.food_idx, 10);
      checkOutput("lit.eatScore", sb.score, 1);
      checkOutput("lit.atePulse", sb.ate, 1);
      sb.tick = 1'b0;
      stepCycle();
      checkOutput("lit.ateDrop", sb.ate, 0);

      sb.tick = 1'b1;
      stepCycle();
      stepCycle();
      checkOutput("lit.midHead", sb.idx_head_now, 47);
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      checkOutput("lit.rstMidHead", sb.idx_head_now, 27);
      checkOutput("lit.rstMidRun", sb.running, 0);
      checkOutput("lit.rstMidScore", sb.score, 0);
      stepCycle();
      checkOutput("lit.idleTickHead", sb.idx_head_now, 27);
      sb.tick = 1'b0;

      sb2.start = 1'b1;
      stepCycle();
      sb2.start        = 1'b0;
      sb2.tick         = 1'b1;
      sb2.new_food_idx = 6'd10;
      stepCycle();
      checkOutput("lit.winFlag", sb2.win, 1);
      checkOutput("lit.winRun", sb2.running, 0);
      checkOutput("lit.winHead", sb2.idx_head_now, 28);
      checkOutput("lit.winFood", sb2.food_idx, 10);
      checkOutput("lit.winAte", sb2.ate, 1);
      stepCycle();
      checkOutput("lit.winFrozenHead", sb2.idx_head_now, 28);
      checkOutput("lit.winFrozenScore", sb2.score, 1);
      sb2.tick  = 1'b0;
      sb2.start = 1'b1;
      stepCycle();
      sb2.start = 1'b0;
      checkOutput("lit.restartRun", sb2.running, 1);
      checkOutput("lit.restartScore", sb2.score, 0);
      checkOutput("lit.restartFood", sb2.food_idx, 28);

      for (int n = 0; n < 4000; n++) applyStimulus();
      rst = 1'b0;
      sb.start = 1'b0;
      sb.tick  = 1'b0;
      stepCycle();
      stepCycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
